// File: rtl/systolic_feeder.sv
// Input skew stage for systolic_array_top: buffers activation rows in a small FIFO and
// issues them diagonally so column k sees its element (with strobe en_k) one cycle after column k-1.
module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x1,
  input  logic signed [WIDTH-1:0] in_x2,
  input  logic signed [WIDTH-1:0] in_x3,
  input  logic                    in_last,
  input  logic                    stall,
  output logic signed [WIDTH-1:0] x1,
  output logic signed [WIDTH-1:0] x2,
  output logic signed [WIDTH-1:0] x3,
  output logic                    en1,
  output logic                    en2,
  output logic                    en3,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic signed [WIDTH-1:0] x1;
    logic signed [WIDTH-1:0] x2;
    logic signed [WIDTH-1:0] x3;
    logic                    last;
  } row_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  row_t            mem [DEPTH];
  row_t            head;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            push, issue;

  state_t          state_q, state_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic            done_c;

  logic            v1, v2, v3;
  logic signed [WIDTH-1:0] d2, d3a, d3b;

  assign head     = mem[rptr];
  assign in_ready = rst_n & (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign issue    = !stall && (count != '0) && (state_q == IDLE || state_q == RUN);

  // NOTE: row storage carries no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{x1: in_x1, x2: in_x2, x3: in_x3, last: in_last};
  end

  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)  wptr <= wptr + AW'(1);
      if (issue) rptr <= rptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Skew pipeline: x2 waits one stage, x3 two; nothing moves while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      x1  <= '0;
      x2  <= '0;
      x3  <= '0;
      d2  <= '0;
      d3a <= '0;
      d3b <= '0;
    end else if (!stall) begin
      v1 <= issue;
      v2 <= v1;
      v3 <= v2;
      if (issue) begin
        x1  <= head.x1;
        d2  <= head.x2;
        d3a <= head.x3;
      end
      if (v1) begin
        x2  <= d2;
        d3b <= d3a;
      end
      if (v2) x3 <= d3b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (issue) begin
          if (head.last) begin
            state_d = DRAIN;
            dcnt_d  = 2'd2;
          end else begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        // The counter hits zero exactly when the last row's x3 is on the bus.
        if (!stall) begin
          if (dcnt_q == 2'd0) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            dcnt_d = dcnt_q - 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign en1  = v1 & !stall;
  assign en2  = v2 & !stall;
  assign en3  = v3 & !stall;
  assign done = done_c & rst_n;
  assign busy = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: scenario tasks with inline cycle checks plus a
// column scoreboard that pairs every strobe with the row element accepted earlier.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_last, stall;
  logic signed [7:0] in_x1, in_x2, in_x3, x1, x2, x3;
  logic en1, en2, en3, busy, done;

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;

  logic signed [7:0] q1[$], q2[$], q3[$];
  logic qlast[$];

  always #5 clk = ~clk;

  systolic_feeder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_last(in_last), .stall(stall),
    .x1(x1), .x2(x2), .x3(x3), .en1(en1), .en2(en2), .en3(en3),
    .busy(busy), .done(done)
  );

  // Scoreboard: compare strobed columns against accepted rows, then record new accepts.
  always @(negedge clk) begin
    logic signed [7:0] e;
    logic exp_done;
    if (mon_on) begin
      exp_done = 1'b0;
      if (en1) begin
        total++;
        if (q1.size() == 0) begin bad++; $display("FAIL sb_en1 unexpected strobe x1=%0d", x1); end
        else begin e = q1.pop_front(); if (x1 !== e) begin bad++; $display("FAIL sb_x1 got=%0d want=%0d", x1, e); end end
      end
      if (en2) begin
        total++;
        if (q2.size() == 0) begin bad++; $display("FAIL sb_en2 unexpected strobe x2=%0d", x2); end
        else begin e = q2.pop_front(); if (x2 !== e) begin bad++; $display("FAIL sb_x2 got=%0d want=%0d", x2, e); end end
      end
      if (en3) begin
        total++;
        if (q3.size() == 0) begin bad++; $display("FAIL sb_en3 unexpected strobe x3=%0d", x3); end
        else begin
          e = q3.pop_front();
          exp_done = qlast.pop_front();
          if (x3 !== e) begin bad++; $display("FAIL sb_x3 got=%0d want=%0d", x3, e); end
        end
      end
      total++;
      if (done !== exp_done) begin bad++; $display("FAIL sb_done got=%b want=%b", done, exp_done); end
      if (!rst_n) begin
        q1.delete(); q2.delete(); q3.delete(); qlast.delete();
      end else if (in_valid && in_ready) begin
        q1.push_back(in_x1); q2.push_back(in_x2); q3.push_back(in_x3); qlast.push_back(in_last);
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic drive_row(input logic signed [7:0] a, b, c, input logic l);
    in_valid = 1'b1; in_x1 = a; in_x2 = b; in_x3 = c; in_last = l;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || q3.size() != 0 || busy) && n < budget) begin
      next(); n++;
    end
    total++;
    if (n >= budget) begin bad++; $display("FAIL drain_timeout busy=%b pending=%0d want idle", busy, q3.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; stall = 1'b0;
    in_x1 = '0; in_x2 = '0; in_x3 = '0;
    repeat (2) next();
    @(negedge clk);
    total++; if ({en1, en2, en3} !== 3'b000) begin bad++; $display("FAIL rst_en got=%b want=000", {en1, en2, en3}); end
    total++; if ({x1, x2, x3} !== 24'h0) begin bad++; $display("FAIL rst_x got=%h want=0", {x1, x2, x3}); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", in_ready); end
    next(); rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", in_ready); end
    mon_on = 1'b1;
  endtask

  task automatic test_single_row();
    drive_row(8'sd44, 8'sd28, 8'sd29, 1'b1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    total++; if (en1 !== 1'b0) begin bad++; $display("FAIL single_early en1 got=%b want=0", en1); end
    next(); @(negedge clk);
    total++; if (en1 !== 1'b1 || x1 !== 8'sd44 || en2 !== 1'b0) begin bad++; $display("FAIL single_c1 en1=%b x1=%0d en2=%b want 1 44 0", en1, x1, en2); end
    next(); @(negedge clk);
    total++; if (en2 !== 1'b1 || x2 !== 8'sd28 || en1 !== 1'b0) begin bad++; $display("FAIL single_c2 en2=%b x2=%0d en1=%b want 1 28 0", en2, x2, en1); end
    next(); @(negedge clk);
    total++; if (en3 !== 1'b1 || x3 !== 8'sd29 || done !== 1'b1) begin bad++; $display("FAIL single_c3 en3=%b x3=%0d done=%b want 1 29 1", en3, x3, done); end
    next(); @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single_end busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    drive_row(8'sd44, 8'sd28, 8'sd29, 1'b0);
    next(); drive_row(8'sd14, 8'sd16, 8'sd21, 1'b1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    total++; if (en1 !== 1'b1 || x1 !== 8'sd44) begin bad++; $display("FAIL b2b_c1 en1=%b x1=%0d want 1 44", en1, x1); end
    next(); @(negedge clk);
    total++; if ({en1, en2} !== 2'b11 || x1 !== 8'sd14 || x2 !== 8'sd28) begin bad++; $display("FAIL b2b_c2 en=%b x1=%0d x2=%0d want 11 14 28", {en1, en2}, x1, x2); end
    next(); @(negedge clk);
    total++; if ({en1, en2, en3} !== 3'b011 || x2 !== 8'sd16 || x3 !== 8'sd29 || done !== 1'b0) begin bad++; $display("FAIL b2b_c3 en=%b x2=%0d x3=%0d done=%b want 011 16 29 0", {en1, en2, en3}, x2, x3, done); end
    next(); @(negedge clk);
    total++; if (en3 !== 1'b1 || x3 !== 8'sd21 || done !== 1'b1) begin bad++; $display("FAIL b2b_c4 en3=%b x3=%0d done=%b want 1 21 1", en3, x3, done); end
    wait_idle(10);
  endtask

  task automatic test_stall();
    drive_row(8'sd44, 8'sd28, 8'sd29, 1'b0);
    next(); drive_row(8'sd14, 8'sd16, 8'sd21, 1'b1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    next(); @(negedge clk);
    total++; if (en2 !== 1'b1 || x2 !== 8'sd28) begin bad++; $display("FAIL stall_first_en2 en2=%b x2=%0d want 1 28", en2, x2); end
    next(); stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({en1, en2, en3} !== 3'b000 || done !== 1'b0) begin bad++; $display("FAIL stall_en cyc=%0d en=%b done=%b want 000 0", i, {en1, en2, en3}, done); end
      total++; if (x1 !== 8'sd14 || x2 !== 8'sd16 || x3 !== 8'sd29) begin bad++; $display("FAIL stall_hold cyc=%0d x=%0d,%0d,%0d want 14,16,29", i, x1, x2, x3); end
      next();
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if ({en2, en3} !== 2'b11 || x2 !== 8'sd16 || x3 !== 8'sd29) begin bad++; $display("FAIL stall_resume en=%b x2=%0d x3=%0d want 11 16 29", {en2, en3}, x2, x3); end
    next(); @(negedge clk);
    total++; if (en3 !== 1'b1 || x3 !== 8'sd21 || done !== 1'b1) begin bad++; $display("FAIL stall_done en3=%b x3=%0d done=%b want 1 21 1", en3, x3, done); end
    wait_idle(10);
  endtask

  task automatic test_backpressure();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_row(8'(10 + i), 8'(20 + i), 8'(30 + i), 1'b0);
      next();
    end
    drive_row(8'sd50, 8'sd60, 8'sd70, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_full cyc=%0d ready=%b busy=%b want 0 1", i, in_ready, busy); end
      next();
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || en1 !== 1'b0) begin bad++; $display("FAIL bp_release ready=%b en1=%b want 0 0", in_ready, en1); end
    next(); @(negedge clk);
    total++; if (in_ready !== 1'b1 || en1 !== 1'b1 || x1 !== 8'sd10) begin bad++; $display("FAIL bp_pop ready=%b en1=%b x1=%0d want 1 1 10", in_ready, en1, x1); end
    next(); in_valid = 1'b0;
    wait_idle(40);
  endtask

  task automatic test_negative();
    drive_row(-8'sd128, -8'sd1, 8'sd127, 1'b1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    next(); @(negedge clk);
    total++; if (en1 !== 1'b1 || x1 !== 8'h80) begin bad++; $display("FAIL neg_x1 en1=%b x1=%h want 1 80", en1, x1); end
    next(); @(negedge clk);
    total++; if (en2 !== 1'b1 || x2 !== 8'hFF) begin bad++; $display("FAIL neg_x2 en2=%b x2=%h want 1 ff", en2, x2); end
    next(); @(negedge clk);
    total++; if (en3 !== 1'b1 || x3 !== 8'h7F) begin bad++; $display("FAIL neg_x3 en3=%b x3=%h want 1 7f", en3, x3); end
    wait_idle(10);
  endtask

  task automatic test_reset_drain();
    drive_row(8'sd5, 8'sd6, 8'sd7, 1'b1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    next(); @(negedge clk);
    total++; if (en1 !== 1'b1 || x1 !== 8'sd5) begin bad++; $display("FAIL rd_en1 en1=%b x1=%0d want 1 5", en1, x1); end
    next(); rst_n = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rd_assert done=%b ready=%b want 0 0", done, in_ready); end
    next(); @(negedge clk);
    total++; if ({en1, en2, en3} !== 3'b000 || {x1, x2, x3} !== 24'h0) begin bad++; $display("FAIL rd_clear en=%b x=%h want 000 0", {en1, en2, en3}, {x1, x2, x3}); end
    total++; if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_flags done=%b ready=%b busy=%b want 0 0 0", done, in_ready, busy); end
    next(); rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rd_release ready=%b busy=%b want 1 0", in_ready, busy); end
    repeat (4) next();
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_negative();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
